// File: rtl/decoder_nx2n_scan_pkg.sv
// Shared types and helpers for the N-to-2^N decoder with direct and scan modes.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Level of an unasserted output bit; replicate across the bus for the full pattern.
  function automatic logic inactive_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/decoder_nx2n_scan_if.sv
// Control and result bus of the decoder; master drives control, slave returns the decode.
interface decoder_nx2n_scan_if #(parameter int N = 3);
  logic            en;
  logic            mode;
  logic [N-1:0]    sel;
  logic            sel_valid;
  logic [2**N-1:0] y;
  logic            y_valid;
  logic [N-1:0]    idx;
  logic            wrap;

  modport master (output en, mode, sel, sel_valid, input y, y_valid, idx, wrap);
  modport slave  (input en, mode, sel, sel_valid, output y, y_valid, idx, wrap);
endinterface

// File: rtl/decoder_nx2n_scan_onehot_dec.sv
// Combinational N-to-2^N one-hot decode, bit 0 is the LSB.
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]    idx,
  output logic [2**N-1:0] oh
);
  localparam int W = 2**N;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign oh[i] = (idx == N'(i));
  end
endmodule

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N decoder: host-selected position (DIRECT) or timed sweep (SCAN).
module decoder_nx2n_scan
  import decoder_pkg::*;
#(
  parameter int N          = 3,
  parameter int DWELL      = 2,
  parameter int ACTIVE_LOW = 0
) (
  input logic              clk,
  input logic              rst,
  decoder_nx2n_scan_if.slave bus
);
  localparam int             W     = 2**N;
  localparam int             CW    = $clog2(DWELL + 1);
  localparam logic [CW-1:0]  DW    = CW'(DWELL);
  localparam logic [W-1:0]   INACT = {W{inactive_level(ACTIVE_LOW != 0)}};

  state_e        state_q, state_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          wrap_q, wrap_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  oh;

  // State register together with the output registers it qualifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      y_q     <= INACT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (bus.en) state_d = (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = '0;
    vld_d  = 1'b0;
    wrap_d = 1'b0;
    unique case (state_d)
      DIRECT: begin
        // Holding in DIRECT keeps the last decode; entering without a strobe shows nothing.
        if (bus.sel_valid) begin
          idx_d = bus.sel;
          vld_d = 1'b1;
        end else begin
          vld_d = (state_q == DIRECT) && vld_q;
        end
      end
      SCAN: begin
        vld_d = 1'b1;
        if (state_q != SCAN) begin
          idx_d = '0;
          cnt_d = CW'(1);
        end else if (cnt_q == DW) begin
          idx_d  = idx_q + N'(1);
          cnt_d  = CW'(1);
          wrap_d = (idx_q == '1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  onehot_dec #(.N(N)) u_dec (.idx(idx_d), .oh(oh));

  always_comb begin
    y_d = INACT;
    if (vld_d) y_d = (ACTIVE_LOW != 0) ? ~oh : oh;
  end

  assign bus.y       = y_q;
  assign bus.y_valid = vld_q;
  assign bus.idx     = idx_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Scoreboard bench: main instance plus active-low and N=1/DWELL=1 corner instances.
module tb_decoder_nx2n_scan;
  typedef struct packed {
    logic       rst;
    logic       en;
    logic       mode;
    logic       sv;
    logic [2:0] sel;
  } stim_t;

  typedef struct packed {
    logic [7:0] y;
    logic       v;
    logic [2:0] idx;
    logic       w;
  } exp_t;

  logic clk, rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  decoder_nx2n_scan_if #(.N(3)) if0 ();
  decoder_nx2n_scan_if #(.N(3)) if1 ();
  decoder_nx2n_scan_if #(.N(1)) if2 ();

  decoder_nx2n_scan #(.N(3), .DWELL(2), .ACTIVE_LOW(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  decoder_nx2n_scan #(.N(3), .DWELL(2), .ACTIVE_LOW(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  decoder_nx2n_scan #(.N(1), .DWELL(1), .ACTIVE_LOW(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

  always #5 clk = ~clk;

  function automatic stim_t st(int r, int en, int m, int v, int sel);
    stim_t s;
    s.rst = r[0]; s.en = en[0]; s.mode = m[0]; s.sv = v[0]; s.sel = sel[2:0];
    return s;
  endfunction

  function automatic exp_t ex(int y, int v, int idx, int w);
    exp_t e;
    e.y = y[7:0]; e.v = v[0]; e.idx = idx[2:0]; e.w = w[0];
    return e;
  endfunction

  task automatic test_reset();
    stim_t s[$]; exp_t e[$]; exp_t o, x;
    s.push_back(st(1,1,1,0,0)); e.push_back(ex(8'h00,0,0,0));
    s.push_back(st(1,1,1,0,0)); e.push_back(ex(8'h00,0,0,0));
    s.push_back(st(0,0,1,0,0)); e.push_back(ex(8'h00,0,0,0));
    foreach (s[i]) begin
      rst = s[i].rst; if0.en = s[i].en; if0.mode = s[i].mode;
      if0.sel_valid = s[i].sv; if0.sel = s[i].sel;
      sb.push_back(e[i]);
      @(posedge clk); #1;
      x = sb.pop_front(); o = {if0.y, if0.y_valid, if0.idx, if0.wrap};
      tests++;
      if (o !== x) begin
        fails++;
        $display("FAIL reset[%0d]: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                 i, o.y, o.v, o.idx, o.w, x.y, x.v, x.idx, x.w);
      end
    end
  endtask

  task automatic test_direct();
    stim_t s[$]; exp_t e[$]; exp_t o, x;
    s.push_back(st(1,0,0,0,0)); e.push_back(ex(8'h00,0,0,0));
    s.push_back(st(0,1,0,0,3)); e.push_back(ex(8'h00,0,0,0));
    for (int k = 0; k < 8; k++) begin
      s.push_back(st(0,1,0,1,k)); e.push_back(ex(1 << k,1,k,0));
    end
    s.push_back(st(0,1,0,0,5)); e.push_back(ex(8'h80,1,7,0));
    s.push_back(st(0,1,0,0,5)); e.push_back(ex(8'h80,1,7,0));
    foreach (s[i]) begin
      rst = s[i].rst; if0.en = s[i].en; if0.mode = s[i].mode;
      if0.sel_valid = s[i].sv; if0.sel = s[i].sel;
      sb.push_back(e[i]);
      @(posedge clk); #1;
      x = sb.pop_front(); o = {if0.y, if0.y_valid, if0.idx, if0.wrap};
      tests++;
      if (o !== x) begin
        fails++;
        $display("FAIL direct[%0d]: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                 i, o.y, o.v, o.idx, o.w, x.y, x.v, x.idx, x.w);
      end
    end
  endtask

  task automatic test_scan();
    stim_t s[$]; exp_t e[$]; exp_t o, x;
    s.push_back(st(1,0,0,0,0)); e.push_back(ex(8'h00,0,0,0));
    // Two cycles per position, so cycle c shows (c/2)%8 and the wrap lands on c=16.
    for (int c = 0; c < 18; c++) begin
      s.push_back(st(0,1,1,c & 1,c)); e.push_back(ex(1 << ((c/2)%8),1,(c/2)%8,(c == 16) ? 1 : 0));
    end
    foreach (s[i]) begin
      rst = s[i].rst; if0.en = s[i].en; if0.mode = s[i].mode;
      if0.sel_valid = s[i].sv; if0.sel = s[i].sel;
      sb.push_back(e[i]);
      @(posedge clk); #1;
      x = sb.pop_front(); o = {if0.y, if0.y_valid, if0.idx, if0.wrap};
      tests++;
      if (o !== x) begin
        fails++;
        $display("FAIL scan[%0d]: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                 i, o.y, o.v, o.idx, o.w, x.y, x.v, x.idx, x.w);
      end
    end
  endtask

  task automatic test_mode_switch();
    stim_t s[$]; exp_t e[$]; exp_t o, x;
    s.push_back(st(1,0,0,0,0)); e.push_back(ex(8'h00,0,0,0));
    for (int c = 0; c < 7; c++) begin
      s.push_back(st(0,1,1,0,0)); e.push_back(ex(1 << (c/2),1,c/2,0));
    end
    s.push_back(st(0,1,0,0,2)); e.push_back(ex(8'h00,0,3,0));
    s.push_back(st(0,1,0,0,2)); e.push_back(ex(8'h00,0,3,0));
    for (int c = 0; c < 7; c++) begin
      s.push_back(st(0,1,1,1,7)); e.push_back(ex(1 << (c/2),1,c/2,0));
    end
    s.push_back(st(0,1,0,1,6)); e.push_back(ex(8'h40,1,6,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'h01,1,0,0));
    foreach (s[i]) begin
      rst = s[i].rst; if0.en = s[i].en; if0.mode = s[i].mode;
      if0.sel_valid = s[i].sv; if0.sel = s[i].sel;
      sb.push_back(e[i]);
      @(posedge clk); #1;
      x = sb.pop_front(); o = {if0.y, if0.y_valid, if0.idx, if0.wrap};
      tests++;
      if (o !== x) begin
        fails++;
        $display("FAIL mode_switch[%0d]: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                 i, o.y, o.v, o.idx, o.w, x.y, x.v, x.idx, x.w);
      end
    end
  endtask

  task automatic test_enable_reset();
    stim_t s[$]; exp_t e[$]; exp_t o, x;
    s.push_back(st(1,0,0,0,0)); e.push_back(ex(8'h00,0,0,0));
    for (int c = 0; c < 11; c++) begin
      s.push_back(st(0,1,1,0,0)); e.push_back(ex(1 << (c/2),1,c/2,0));
    end
    s.push_back(st(0,0,1,1,2)); e.push_back(ex(8'h00,0,5,0));
    s.push_back(st(0,0,0,1,2)); e.push_back(ex(8'h00,0,5,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'h01,1,0,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'h01,1,0,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'h02,1,1,0));
    s.push_back(st(1,1,1,1,4)); e.push_back(ex(8'h00,0,0,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'h01,1,0,0));
    foreach (s[i]) begin
      rst = s[i].rst; if0.en = s[i].en; if0.mode = s[i].mode;
      if0.sel_valid = s[i].sv; if0.sel = s[i].sel;
      sb.push_back(e[i]);
      @(posedge clk); #1;
      x = sb.pop_front(); o = {if0.y, if0.y_valid, if0.idx, if0.wrap};
      tests++;
      if (o !== x) begin
        fails++;
        $display("FAIL enable_reset[%0d]: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                 i, o.y, o.v, o.idx, o.w, x.y, x.v, x.idx, x.w);
      end
    end
  endtask

  task automatic test_active_low();
    stim_t s[$]; exp_t e[$]; exp_t o, x;
    s.push_back(st(1,1,1,0,0)); e.push_back(ex(8'hFF,0,0,0));
    s.push_back(st(0,1,0,1,2)); e.push_back(ex(8'hFB,1,2,0));
    s.push_back(st(0,1,0,0,5)); e.push_back(ex(8'hFB,1,2,0));
    s.push_back(st(0,0,0,0,0)); e.push_back(ex(8'hFF,0,2,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'hFE,1,0,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'hFE,1,0,0));
    s.push_back(st(0,1,1,0,0)); e.push_back(ex(8'hFD,1,1,0));
    foreach (s[i]) begin
      rst = s[i].rst; if1.en = s[i].en; if1.mode = s[i].mode;
      if1.sel_valid = s[i].sv; if1.sel = s[i].sel;
      sb.push_back(e[i]);
      @(posedge clk); #1;
      x = sb.pop_front(); o = {if1.y, if1.y_valid, if1.idx, if1.wrap};
      tests++;
      if (o !== x) begin
        fails++;
        $display("FAIL active_low[%0d]: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                 i, o.y, o.v, o.idx, o.w, x.y, x.v, x.idx, x.w);
      end
    end
    if1.en = 1'b0;
  endtask

  task automatic test_n1_dwell1();
    stim_t s[$]; exp_t e[$]; exp_t o, x;
    s.push_back(st(1,1,1,0,0)); e.push_back(ex(8'h00,0,0,0));
    for (int c = 0; c < 6; c++) begin
      s.push_back(st(0,1,1,0,0)); e.push_back(ex(1 << (c%2),1,c%2,(c > 0 && c%2 == 0) ? 1 : 0));
    end
    s.push_back(st(0,0,1,0,0)); e.push_back(ex(8'h00,0,1,0));
    foreach (s[i]) begin
      rst = s[i].rst; if2.en = s[i].en; if2.mode = s[i].mode;
      if2.sel_valid = s[i].sv; if2.sel = s[i].sel[0];
      sb.push_back(e[i]);
      @(posedge clk); #1;
      x = sb.pop_front(); o = {6'b0, if2.y, if2.y_valid, 2'b0, if2.idx, if2.wrap};
      tests++;
      if (o !== x) begin
        fails++;
        $display("FAIL n1_dwell1[%0d]: got y=%h v=%b idx=%0d wrap=%b, want y=%h v=%b idx=%0d wrap=%b",
                 i, o.y, o.v, o.idx, o.w, x.y, x.v, x.idx, x.w);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    if0.en = 1'b0; if0.mode = 1'b0; if0.sel_valid = 1'b0; if0.sel = '0;
    if1.en = 1'b0; if1.mode = 1'b0; if1.sel_valid = 1'b0; if1.sel = '0;
    if2.en = 1'b0; if2.mode = 1'b0; if2.sel_valid = 1'b0; if2.sel = '0;
    #1;
    test_reset();
    test_direct();
    test_scan();
    test_mode_switch();
    test_enable_reset();
    if0.en = 1'b0;
    test_active_low();
    test_n1_dwell1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decoder_nx2n_scan.md
Name: decoder_nx2n_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. It generalises the team's 3-to-8 decoder and adds an enable, output polarity selection, and an auto-scan mode.
- In DIRECT mode it decodes a host-supplied select on a valid strobe.
- In SCAN mode it sweeps the one-hot output through every position, holding each position for DWELL cycles. Used for row/column strobing and chip-select sequencing.
- Sits between control logic and the strobed resources. All outputs are registered.

Parameters:
- N, 3, select width; output width is 2^N (N >= 1).
- DWELL, 2, cycles each position is held in SCAN mode (DWELL >= 1).
- ACTIVE_LOW, 0, 1 = asserted output bit is 0 and inactive bits are 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; 0 forces IDLE.
- mode  input  1  0 = DIRECT, 1 = SCAN; sampled every cycle while en = 1.
- sel  input  N  select index, DIRECT mode only.
- sel_valid  input  1  captures sel in DIRECT mode; ignored elsewhere.
- y  output  2^N  one-hot decoded output, polarity per ACTIVE_LOW.
- y_valid  output  1  y currently holds a decoded position.
- idx  output  N  index currently driven on y.
- wrap  output  1  one-cycle pulse when SCAN wraps from 2^N-1 to 0.

Behaviour:
- Reset: rst is synchronous, active-high and overrides everything.
  - One cycle after rst is sampled high: state = IDLE, y = all-inactive (0s, or 1s when ACTIVE_LOW), y_valid = 0, idx = 0, wrap = 0, dwell counter = 0.
  - Asserting rst mid-scan or mid-hold gives the same result; there is no partial state.
- Inactive pattern: "inactive" below always means all bits at the inactive level for the configured ACTIVE_LOW.
- Latency: every output changes exactly 1 cycle after the inputs that cause it are sampled. There is no combinational path from inputs to outputs.
- Next state is evaluated every cycle:
  - en = 0 -> IDLE.
  - en = 1 and mode = 0 -> DIRECT.
  - en = 1 and mode = 1 -> SCAN.
- IDLE:
  - y inactive, y_valid = 0, wrap = 0.
  - idx holds its last value; dwell counter cleared.
- DIRECT:
  - sel_valid = 1 -> next cycle: y = onehot(sel), idx = sel, y_valid = 1.
  - sel_valid = 0 -> y, idx and y_valid hold.
  - Entry from IDLE or SCAN with sel_valid = 0 -> y inactive, y_valid = 0 until the first sel_valid.
  - Entry with sel_valid = 1 in the same cycle -> loads sel directly.
  - wrap = 0 throughout.
- SCAN:
  - Entry from any other state -> next cycle: idx = 0, y = onehot(0), y_valid = 1, dwell counter = 1, wrap = 0.
  - While in SCAN, each idx value is shown for exactly DWELL cycles, then idx increments.
  - DWELL = 1 advances every cycle.
  - At idx = 2^N-1 the next step goes to idx = 0, and wrap = 1 for exactly the first cycle idx = 0 is shown. The initial entry at idx = 0 does not pulse wrap.
  - sel and sel_valid are ignored.
- Mode switch mid-operation: takes effect on the next cycle with the entry rules above. A scan is never resumed; it always restarts at 0.
- Arithmetic widths:
  - idx increments modulo 2^N.
  - Dwell counter is clog2(DWELL+1) bits wide and never overflows.
  - onehot(k) sets only bit k; bit 0 is the LSB.
- Invariant: whenever y_valid = 1, exactly one bit of y is at the asserted level and it equals bit idx.

Decomposition:
- Shared package decoder_pkg:
  - state enum {IDLE, DIRECT, SCAN}.
  - MODE_DIRECT = 0 and MODE_SCAN = 1 constants.
  - Function returning the inactive pattern for a given ACTIVE_LOW.
- One combinational sub-module, onehot_dec:
  - Parametrised N-to-2^N decode of idx_next.
  - Its output is registered and polarity-applied in the top level.

Test Plan (N = 3, DWELL = 2, ACTIVE_LOW = 0 unless stated):
- Reset: rst = 1 for 2 cycles with en = 1, mode = 1 -> y = 8'h00, y_valid = 0, idx = 0, wrap = 0 one cycle after the first rst sample.
- DIRECT sweep: en = 1, mode = 0, sel = 0..7 each with sel_valid = 1 -> y = 8'h01, 02, 04, ..., 80, each one cycle later, y_valid = 1. Then drop sel_valid with sel = 5 -> y holds 8'h80.
- SCAN full cycle: en = 1, mode = 1 for 18 cycles -> y = 01,01,02,02,...,80,80,01. wrap = 1 only on the cycle y returns to 8'h01 (cycle 17 after entry), never on the first cycle.
- Mode switch mid-scan:
  - At idx = 3, set mode = 0 with sel_valid = 0 -> next cycle y = 00, y_valid = 0.
  - Later set mode = 1 -> scan restarts with y = 8'h01.
  - Repeat the switch with sel_valid = 1, sel = 6 -> y = 8'h40 next cycle.
- Enable and reset mid-operation:
  - en = 0 during SCAN at idx = 5 -> y = 00, y_valid = 0, idx stays 5.
  - rst = 1 during SCAN -> idx = 0, outputs reset.
- Parameter corners:
  - ACTIVE_LOW = 1, DIRECT sel = 2 -> y = 8'hFB; IDLE -> y = 8'hFF.
  - N = 1, DWELL = 1, SCAN -> y alternates 2'b01/2'b10, with wrap on every return to 01.
